// File: rtl/if_fetch.sv
// Instruction-fetch stage: arbitrates the shared SRAM against MEM, runs a
// timed read handshake and presents instruction/PC/delay-slot to ID.
module if_fetch #(
   parameter int unsigned TIMEOUT  = 8,
   parameter logic [15:0] NOP_INST = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pc_i,
   input  logic        ce_i,
   input  logic        in_delay_slot_i,
   input  logic [5:0]  stall,
   input  logic        flush_i,
   input  logic        mem_req_i,
   output logic        ram_rd_o,
   output logic [15:0] ram_addr_o,
   input  logic [15:0] ram_data_i,
   input  logic        ram_ready_i,
   output logic        stallreq_o,
   output logic [15:0] if_pc_o,
   output logic [15:0] if_inst_o,
   output logic        if_in_delay_slot_o,
   output logic        if_valid_o,
   output logic        if_fetch_err_o
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT_ID} state_t;

   state_t      state_q, state_d;
   logic [15:0] fetch_pc_q, fetch_pc_d;
   logic        fetch_ds_q, fetch_ds_d;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;
   logic [15:0] hb_inst_q, hb_inst_d, hb_pc_q, hb_pc_d;
   logic        hb_ds_q, hb_ds_d, hb_err_q, hb_err_d;
   logic        ram_rd_q, ram_rd_d;
   logic [15:0] ram_addr_q, ram_addr_d;
   logic [15:0] if_pc_q, if_pc_d, if_inst_q, if_inst_d;
   logic        if_ds_q, if_ds_d, if_valid_q, if_valid_d, if_err_q, if_err_d;

   logic        id_stop, tmo_hit, fetch_done, complete, done_err;
   logic [15:0] done_inst;
   logic        unused_stall;

   assign id_stop      = stall[1];
   assign unused_stall = ^{stall[5:2], stall[0]};

   always_comb begin
      tmo_hit    = (tmo_cnt_q == 8'(TIMEOUT - 1));
      fetch_done = (state_q == FETCH) && (ram_ready_i || tmo_hit);
      // A flush in the completing cycle discards the returned data.
      complete   = fetch_done && !flush_i;
      done_inst  = ram_ready_i ? ram_data_i : NOP_INST;
      done_err   = !ram_ready_i;
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      fetch_ds_d = fetch_ds_q;
      tmo_cnt_d  = tmo_cnt_q;
      hb_inst_d  = hb_inst_q;
      hb_pc_d    = hb_pc_q;
      hb_ds_d    = hb_ds_q;
      hb_err_d   = hb_err_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_ds_d    = if_ds_q;
      if_valid_d = if_valid_q;
      if_err_d   = if_err_q;
      ram_addr_d = ram_addr_q;

      if (flush_i) begin
         state_d    = IDLE;
         hb_inst_d  = NOP_INST;
         hb_ds_d    = 1'b0;
         hb_err_d   = 1'b0;
         if_inst_d  = NOP_INST;
         if_ds_d    = 1'b0;
         if_valid_d = 1'b0;
         if_err_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ce_i && !mem_req_i) begin
                  fetch_pc_d = pc_i;
                  fetch_ds_d = in_delay_slot_i;
                  tmo_cnt_d  = 8'd0;
                  state_d    = FETCH;
               end
            end
            FETCH: begin
               if (fetch_done) begin
                  if (id_stop) begin
                     hb_inst_d = done_inst;
                     hb_pc_d   = fetch_pc_q;
                     hb_ds_d   = fetch_ds_q;
                     hb_err_d  = done_err;
                     state_d   = WAIT_ID;
                  end else begin
                     state_d   = IDLE;
                  end
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 8'd1;
               end
            end
            WAIT_ID: if (!id_stop) state_d = IDLE;
            default: state_d = IDLE;
         endcase

         if (!id_stop) begin
            if (complete) begin
               if_pc_d    = fetch_pc_q;
               if_inst_d  = done_inst;
               if_ds_d    = fetch_ds_q;
               if_valid_d = 1'b1;
               if_err_d   = done_err;
            end else if (state_q == WAIT_ID) begin
               if_pc_d    = hb_pc_q;
               if_inst_d  = hb_inst_q;
               if_ds_d    = hb_ds_q;
               if_valid_d = 1'b1;
               if_err_d   = hb_err_q;
            end else begin
               if_inst_d  = NOP_INST;
               if_ds_d    = 1'b0;
               if_valid_d = 1'b0;
               if_err_d   = 1'b0;
            end
         end
      end

      ram_rd_d = (state_d == FETCH);
      if (state_d == FETCH) ram_addr_d = fetch_pc_d;
   end

   always_comb begin
      stallreq_o = 1'b0;
      case (state_q)
         IDLE:    stallreq_o = ce_i && !flush_i;
         FETCH:   stallreq_o = !complete;
         default: stallreq_o = 1'b0;
      endcase
      if (rst) stallreq_o = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= 16'd0;
         fetch_ds_q <= 1'b0;
         tmo_cnt_q  <= 8'd0;
         hb_inst_q  <= NOP_INST;
         hb_pc_q    <= 16'd0;
         hb_ds_q    <= 1'b0;
         hb_err_q   <= 1'b0;
         ram_rd_q   <= 1'b0;
         ram_addr_q <= 16'd0;
         if_pc_q    <= 16'd0;
         if_inst_q  <= NOP_INST;
         if_ds_q    <= 1'b0;
         if_valid_q <= 1'b0;
         if_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         fetch_ds_q <= fetch_ds_d;
         tmo_cnt_q  <= tmo_cnt_d;
         hb_inst_q  <= hb_inst_d;
         hb_pc_q    <= hb_pc_d;
         hb_ds_q    <= hb_ds_d;
         hb_err_q   <= hb_err_d;
         ram_rd_q   <= ram_rd_d;
         ram_addr_q <= ram_addr_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_ds_q    <= if_ds_d;
         if_valid_q <= if_valid_d;
         if_err_q   <= if_err_d;
      end
   end

   assign ram_rd_o           = ram_rd_q;
   assign ram_addr_o         = ram_addr_q;
   assign if_pc_o            = if_pc_q;
   assign if_inst_o          = if_inst_q;
   assign if_in_delay_slot_o = if_ds_q;
   assign if_valid_o         = if_valid_q;
   assign if_fetch_err_o     = if_err_q;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a transaction-level fetch model queues the
// instructions ID should see; a monitor pops them whenever IF/ID reloads.
module tb_if_fetch;
   localparam int          TMO = 8;
   localparam logic [15:0] NOP = 16'h0800;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, ce_i, ds_i, flush_i, mem_req_i, ram_ready_i;
   logic [15:0] pc_i, ram_data_i;
   logic [5:0]  stall;
   logic        ram_rd_o, stallreq_o, if_ds_o, if_valid_o, if_err_o;
   logic [15:0] ram_addr_o, if_pc_o, if_inst_o;

   if_fetch #(.TIMEOUT(TMO), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .in_delay_slot_i(ds_i),
      .stall(stall), .flush_i(flush_i), .mem_req_i(mem_req_i),
      .ram_rd_o(ram_rd_o), .ram_addr_o(ram_addr_o), .ram_data_i(ram_data_i),
      .ram_ready_i(ram_ready_i), .stallreq_o(stallreq_o), .if_pc_o(if_pc_o),
      .if_inst_o(if_inst_o), .if_in_delay_slot_o(if_ds_o),
      .if_valid_o(if_valid_o), .if_fetch_err_o(if_err_o));

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] inst;
      logic        ds;
      logic        err;
   } item_t;

   item_t       exp_q[$];
   int          errors = 0;
   int          checks = 0;

   // Reference: one outstanding fetch, or one finished item waiting for ID.
   bit          m_busy = 1'b0;
   bit          m_hold = 1'b0;
   logic [15:0] m_pc   = 16'd0;
   logic        m_ds   = 1'b0;
   int          m_age  = 0;
   item_t       m_hold_item;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_stallreq();
      if (rst || m_hold) return 1'b0;
      if (m_busy) return !((ram_ready_i || m_age == TMO - 1) && !flush_i);
      return ce_i && !flush_i;
   endfunction

   task automatic model_update();
      item_t it;
      if (rst || flush_i) begin
         m_busy = 1'b0;
         m_hold = 1'b0;
      end else if (m_hold) begin
         if (!stall[1]) begin
            exp_q.push_back(m_hold_item);
            m_hold = 1'b0;
         end
      end else if (m_busy) begin
         if (ram_ready_i || m_age == TMO - 1) begin
            it.pc   = m_pc;
            it.inst = ram_ready_i ? ram_data_i : NOP;
            it.ds   = m_ds;
            it.err  = !ram_ready_i;
            if (stall[1]) begin
               m_hold      = 1'b1;
               m_hold_item = it;
            end else begin
               exp_q.push_back(it);
            end
            m_busy = 1'b0;
         end else begin
            m_age++;
         end
      end else if (ce_i && !mem_req_i) begin
         m_busy = 1'b1;
         m_pc   = pc_i;
         m_ds   = ds_i;
         m_age  = 0;
      end
   endtask

   task automatic cyc(input logic r, input logic c, input logic [15:0] p, input logic d,
                      input logic s1, input logic fl, input logic mr, input logic rdy,
                      input logic [15:0] dat);
      rst = r; ce_i = c; pc_i = p; ds_i = d; flush_i = fl; mem_req_i = mr;
      ram_ready_i = rdy; ram_data_i = dat;
      stall = 6'($urandom);
      stall[1] = s1;
      #1;
      chk("stallreq", 32'(stallreq_o), 32'(exp_stallreq()));
      chk("ram_rd", 32'(ram_rd_o), 32'(m_busy));
      if (m_busy) chk("ram_addr", 32'(ram_addr_o), 32'(m_pc));
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   // Monitor: whenever IF/ID reloads, it shows the next queued item or a bubble.
   logic [15:0] last_pc = 16'd0;
   initial begin : monitor
      item_t it;
      logic  r, rl;
      forever begin
         @(posedge clk);
         r  = rst;
         rl = rst || flush_i || !stall[1];
         #1;
         if (r) begin
            chk("rst_valid", 32'(if_valid_o), 32'd0);
            chk("rst_inst", 32'(if_inst_o), 32'(NOP));
            chk("rst_pc", 32'(if_pc_o), 32'd0);
            chk("rst_ds_err", 32'({if_ds_o, if_err_o}), 32'd0);
            chk("rst_ram", 32'({ram_rd_o, ram_addr_o}), 32'd0);
            last_pc = 16'd0;
         end else if (rl) begin
            if (if_valid_o) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_valid", 32'(if_inst_o), 32'(NOP));
                  chk("unexpected_valid_flag", 32'(if_valid_o), 32'd0);
               end else begin
                  it = exp_q.pop_front();
                  chk("if_pc", 32'(if_pc_o), 32'(it.pc));
                  chk("if_inst", 32'(if_inst_o), 32'(it.inst));
                  chk("if_ds", 32'(if_ds_o), 32'(it.ds));
                  chk("if_err", 32'(if_err_o), 32'(it.err));
                  last_pc = it.pc;
               end
            end else begin
               chk("missing_valid", 32'(exp_q.size()), 32'd0);
               chk("bubble_inst", 32'(if_inst_o), 32'(NOP));
               chk("bubble_ds_err", 32'({if_ds_o, if_err_o}), 32'd0);
               chk("bubble_pc", 32'(if_pc_o), 32'(last_pc));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; ce_i = 1'b0; pc_i = 16'd0; ds_i = 1'b0; flush_i = 1'b0;
      mem_req_i = 1'b0; ram_ready_i = 1'b0; ram_data_i = 16'd0; stall = 6'd0;
      @(posedge clk);
      model_update();
      @(negedge clk);
      cyc(1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
      // Best case: latch pc 0, ready in first FETCH cycle.
      cyc(0, 1, 16'h0000, 0, 0, 0, 0, 0, 16'h1111);
      cyc(0, 1, 16'h0001, 0, 0, 0, 0, 1, 16'h6A05);
      cyc(0, 0, 16'h0001, 0, 0, 0, 0, 0, 16'h0000);
      // MEM claims the SRAM for three cycles.
      for (int i = 0; i < 3; i++) cyc(0, 1, 16'h0010, 0, 0, 0, 1, 0, 16'h0000);
      cyc(0, 1, 16'h0010, 0, 0, 0, 0, 0, 16'h0000);
      cyc(0, 0, 16'h0010, 0, 0, 0, 1, 1, 16'h2222);
      // Ready while ID stopped for two cycles.
      cyc(0, 1, 16'h0020, 0, 0, 0, 0, 0, 16'h0000);
      cyc(0, 1, 16'h0021, 0, 1, 0, 0, 1, 16'h4F01);
      cyc(0, 1, 16'h0021, 0, 1, 0, 0, 0, 16'h0000);
      cyc(0, 1, 16'h0021, 0, 0, 0, 0, 0, 16'h0000);
      cyc(0, 0, 16'h0021, 0, 0, 0, 0, 0, 16'h0000);
      // Timeout, then a normal fetch.
      cyc(0, 1, 16'h0030, 0, 0, 0, 0, 0, 16'h0000);
      for (int i = 0; i < TMO; i++) cyc(0, 0, 16'h0031, 0, 0, 0, 0, 0, 16'h3333);
      cyc(0, 1, 16'h0031, 0, 0, 0, 0, 0, 16'h0000);
      cyc(0, 1, 16'h0032, 0, 0, 0, 0, 1, 16'h5555);
      // Delay-slot instruction followed by a normal one.
      cyc(0, 1, 16'h0024, 1, 0, 0, 0, 0, 16'h0000);
      cyc(0, 1, 16'h0025, 0, 0, 0, 0, 1, 16'h7777);
      cyc(0, 1, 16'h0025, 0, 0, 0, 0, 0, 16'h0000);
      cyc(0, 0, 16'h0026, 0, 0, 0, 0, 1, 16'h8888);
      // Flush in second FETCH cycle with ready the same cycle.
      cyc(0, 1, 16'h0040, 0, 0, 0, 0, 0, 16'h0000);
      cyc(0, 0, 16'h0041, 0, 0, 0, 0, 0, 16'h0000);
      cyc(0, 0, 16'h0041, 0, 0, 1, 0, 1, 16'h9999);
      cyc(0, 0, 16'h0041, 0, 0, 0, 0, 1, 16'h9999);
      // Reset mid-FETCH.
      cyc(0, 1, 16'h0050, 1, 0, 0, 0, 0, 16'h0000);
      cyc(0, 0, 16'h0051, 0, 0, 0, 0, 0, 16'h0000);
      cyc(1, 0, 16'h0051, 0, 0, 0, 0, 1, 16'hAAAA);
      cyc(0, 0, 16'h0051, 0, 0, 0, 0, 1, 16'hAAAA);
      // Randomized traffic.
      for (int i = 0; i < 3000; i++)
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 85), 16'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < 25),
             ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 20),
             ($urandom_range(0, 99) < 35), 16'($urandom));
      cyc(0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
